// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg -- shared definitions for the two-host ROM arbiter.
//   NumHosts   : number of requesting hosts (fixed at 2)
//   host_idx_t : index type wide enough to name one host
//   in_range() : true when a word index falls inside the ROM
package rom_arb_pkg;

    localparam int NumHosts = 2;

    typedef logic [$clog2(NumHosts)-1:0] host_idx_t;

    // Both operands are widened to 64 bits so any AW/ROM_WORDS pair compares correctly.
    function automatic logic in_range(input logic [63:0] word_idx,
                                      input logic [63:0] rom_words);
        return word_idx < rom_words;
    endfunction

endpackage

// File: rtl/rom_arb_sel.sv
// rom_arb_sel -- 2-way grant selector.
//   clk_i, rst_ni : clock / asynchronous active-low reset (round-robin pointer only)
//   req_i         : per-host request
//   gnt_o         : one-hot grant, zero when nothing is requested
//   idx_o         : index of the granted host (0 when no grant)
// Build option: define ROM_ARB_RR_EN for round-robin arbitration; otherwise
// host 0 has fixed priority and no pointer state exists.
module rom_arb_sel
    import rom_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumHosts-1:0] req_i,
    output logic [NumHosts-1:0] gnt_o,
    output host_idx_t           idx_o
);

`ifdef ROM_ARB_RR_EN
    host_idx_t last_q, last_d;
    host_idx_t win;

    always_comb begin
        win    = '0;
        gnt_o  = '0;
        last_d = last_q;
        unique case (req_i)
            2'b01:   win = host_idx_t'(0);
            2'b10:   win = host_idx_t'(1);
            2'b11:   win = ~last_q;   // the host that did not win last time
            default: win = '0;
        endcase
        if (|req_i) begin
            gnt_o[win] = 1'b1;
            last_d     = win;
        end
        idx_o = win;
    end

    // Pointer resets to host 1 so host 0 wins the first contested cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= host_idx_t'(1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        if (req_i[0]) begin
            gnt_o[0] = 1'b1;
            idx_o    = host_idx_t'(0);
        end else if (req_i[1]) begin
            gnt_o[1] = 1'b1;
            idx_o    = host_idx_t'(1);
        end
    end
`endif

endmodule

// File: rtl/rom_arb.sv
// rom_arb -- two hosts share one single-cycle-latency ROM.
//   Parameters : AW (address width), DW (data width), ROM_WORDS (ROM depth in words)
//   clk_i, rst_ni         : clock / asynchronous active-low reset
//   h_req_i, h_addr_i     : per-host request and byte address (bits [1:0] ignored)
//   h_gnt_o               : combinational one-hot grant
//   h_rvalid_o, h_err_o   : per-host response valid / error, one cycle after grant
//   h_rdata_o             : shared response data, zero unless a response is valid
//   mem_req_o, mem_addr_o : ROM read request and word index
//   mem_rdata_i, mem_rvalid_i : ROM response, one cycle after mem_req_o
// Build option: ROM_ARB_RR_EN selects round-robin instead of fixed priority.
module rom_arb
    import rom_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int ROM_WORDS = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumHosts-1:0]          h_req_i,
    input  logic [NumHosts-1:0][AW-1:0]  h_addr_i,
    output logic [NumHosts-1:0]          h_gnt_o,
    output logic [NumHosts-1:0]          h_rvalid_o,
    output logic [NumHosts-1:0]          h_err_o,
    output logic [DW-1:0]                h_rdata_o,
    output logic                         mem_req_o,
    output logic [AW-1:0]                mem_addr_o,
    input  logic [DW-1:0]                mem_rdata_i,
    input  logic                         mem_rvalid_i
);

    logic [NumHosts-1:0] gnt;
    host_idx_t           gidx;
    logic                gnt_any;
    logic [AW-1:0]       sel_addr;
    logic [AW-3:0]       word;
    logic                in_rng;
    logic                unused_lsb;

    logic      pend_q, pend_d;
    host_idx_t owner_q, owner_d;
    logic      err_q, err_d;

    rom_arb_sel u_sel (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (h_req_i),
        .gnt_o  (gnt),
        .idx_o  (gidx)
    );

    assign h_gnt_o    = gnt;
    assign gnt_any    = |gnt;
    assign sel_addr   = h_addr_i[gidx];
    assign word       = sel_addr[AW-1:2];
    assign unused_lsb = ^sel_addr[1:0];
    assign in_rng     = in_range(64'(word), 64'(ROM_WORDS));

    // Memory side is forced quiet while reset is asserted; the grant is not.
    assign mem_req_o  = rst_ni & gnt_any & in_rng;
    assign mem_addr_o = rst_ni ? {2'b00, word} : '0;

    // Tracker captures every grant; an idle cycle clears it.
    always_comb begin
        pend_d  = gnt_any;
        owner_d = gnt_any ? gidx : '0;
        err_d   = gnt_any & ~in_rng;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= 1'b0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Error responses are generated locally and never wait on the ROM; a
    // ROM response that arrives with nothing in-range pending is dropped.
    always_comb begin
        h_rvalid_o = '0;
        h_err_o    = '0;
        h_rdata_o  = '0;
        if (pend_q && err_q) begin
            h_rvalid_o[owner_q] = 1'b1;
            h_err_o[owner_q]    = 1'b1;
        end else if (pend_q && mem_rvalid_i) begin
            h_rvalid_o[owner_q] = 1'b1;
            h_rdata_o           = mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_rom_arb.sv
module tb_rom_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 256;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [1:0]          h_req = '0;
    logic [1:0][AW-1:0]  h_addr = '0;
    logic [1:0]          h_gnt, h_rvalid, h_err;
    logic [DW-1:0]       h_rdata;
    logic                mem_req;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_rdata;
    logic                mem_rvalid;

    rom_arb #(.AW(AW), .DW(DW), .ROM_WORDS(RW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .h_req_i      (h_req),
        .h_addr_i     (h_addr),
        .h_gnt_o      (h_gnt),
        .h_rvalid_o   (h_rvalid),
        .h_err_o      (h_err),
        .h_rdata_o    (h_rdata),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .mem_rvalid_i (mem_rvalid)
    );

    always #5 clk = ~clk;

    // ROM behaviour: answers every request exactly one cycle later.
    logic [DW-1:0] rom [RW];
    logic          rv_q = 1'b0;
    logic          spur = 1'b0;
    logic [DW-1:0] rd_q = '0;

    always @(posedge clk) begin
        rv_q <= mem_req;
        rd_q <= rom[mem_addr[7:0]];
    end
    assign mem_rvalid = rv_q | spur;
    assign mem_rdata  = rd_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state: who won last, and the previous cycle's grant.
    int            m_last = 1;
    logic          p_v = 1'b0;
    int            p_h = 0;
    logic [AW-1:0] p_a = '0;

    function automatic int winner(input logic [1:0] r);
        if (r == 2'b00) return -1;
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef ROM_ARB_RR_EN
        return (m_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_last = 1;
        p_v    = 1'b0;
        p_h    = 0;
        p_a    = '0;
    endtask

    task automatic do_cycle(input logic [1:0] req, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1, input logic sp, output int g);
        logic [1:0]    e_gnt, e_rv, e_err;
        logic [DW-1:0] e_rd;
        logic [AW-1:0] ga;
        logic          inr;
        int            pw;
        @(negedge clk);
        h_req     = req;
        h_addr[0] = a0;
        h_addr[1] = a1;
        spur      = sp;
        #1;
        g     = winner(req);
        e_gnt = '0;
        ga    = '0;
        inr   = 1'b0;
        if (g >= 0) begin
            e_gnt[g] = 1'b1;
            ga       = (g == 0) ? a0 : a1;
            inr      = (ga >> 2) < RW;
        end
        check("gnt", 64'(h_gnt), 64'(e_gnt));
        check("mem_req", 64'(mem_req), 64'(inr));
        if (inr) check("mem_addr", 64'(mem_addr), 64'(ga >> 2));
        e_rv  = '0;
        e_err = '0;
        e_rd  = '0;
        if (p_v) begin
            e_rv[p_h] = 1'b1;
            pw = int'(p_a >> 2);
            if ((p_a >> 2) >= RW) e_err[p_h] = 1'b1;
            else                  e_rd = rom[pw];
        end
        check("rvalid", 64'(h_rvalid), 64'(e_rv));
        check("err", 64'(h_err), 64'(e_err));
        check("rdata", 64'(h_rdata), 64'(e_rd));
        p_v = (g >= 0);
        p_h = (g >= 0) ? g : 0;
        p_a = ga;
        if (g >= 0) m_last = g;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        case ($urandom % 3)
            0:       a = AW'(($urandom_range(0, RW - 1) << 2) | ($urandom % 4));
            1:       a = AW'($urandom_range(RW, 4 * RW) << 2);
            default: a = AW'($urandom);
        endcase
        return a;
    endfunction

    initial begin
        int g;
        int gl;
        logic [1:0]         hr;
        logic [1:0][AW-1:0] ha;

        for (int i = 0; i < RW; i++) rom[i] = $urandom;
        rom[4] = 32'hDEADBEEF;

        // Reset state, with a contested in-range request present.
        rst_n     = 1'b0;
        h_req     = 2'b11;
        h_addr[0] = '0;
        h_addr[1] = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", 64'(h_gnt), 64'(2'b01));
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_rvalid", 64'(h_rvalid), 64'd0);
        check("rst_err", 64'(h_err), 64'd0);
        check("rst_rdata", 64'(h_rdata), 64'd0);
        h_req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single in-range read of word 4.
        do_cycle(2'b01, 32'h10, 32'h0, 1'b0, g);
        check("d_addr4", 64'(mem_addr), 64'd4);
        do_cycle(2'b00, 32'h0, 32'h0, 1'b0, g);
        check("d_rdata4", 64'(h_rdata), 64'hDEADBEEF);

        // Both hosts every cycle: alternation or starvation.
        gl = -1;
        for (int i = 0; i < 6; i++) begin
            do_cycle(2'b11, AW'(i * 4), AW'(i * 8 + 1), 1'b0, g);
`ifdef ROM_ARB_RR_EN
            if (gl >= 0) check("rr_alt", 64'(g), 64'(1 - gl));
`else
            check("fixed_h0", 64'(g), 64'd0);
`endif
            gl = g;
        end

        // Out-of-range host1 request, and the range boundary words.
        do_cycle(2'b10, 32'h0, 32'h400, 1'b0, g);
        check("d_oor_memreq", 64'(mem_req), 64'd0);
        do_cycle(2'b01, AW'(255 * 4 + 3), 32'h0, 1'b0, g);
        do_cycle(2'b10, 32'h0, AW'(256 * 4), 1'b0, g);
        do_cycle(2'b00, 32'h0, 32'h0, 1'b0, g);

        // Reset pulse with a response in flight.
        do_cycle(2'b01, 32'h20, 32'h0, 1'b0, g);
        h_req = 2'b00;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_drop_rvalid", 64'(h_rvalid), 64'd0);
        check("rst_drop_rdata", 64'(h_rdata), 64'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_cycle(2'b00, 32'h0, 32'h0, 1'b0, g);
        do_cycle(2'b00, 32'h0, 32'h0, 1'b0, g);
        do_cycle(2'b01, 32'h8, 32'h0, 1'b0, g);
        do_cycle(2'b00, 32'h0, 32'h0, 1'b0, g);

        // Spurious ROM responses with nothing pending.
        do_cycle(2'b00, 32'h0, 32'h0, 1'b1, g);
        do_cycle(2'b00, 32'h0, 32'h0, 1'b1, g);

        // Random traffic: each host holds its request until granted.
        hr = '0;
        ha = '0;
        for (int i = 0; i < 400; i++) begin
            for (int h = 0; h < 2; h++) begin
                if (!hr[h] && ($urandom % 4 != 0)) begin
                    hr[h] = 1'b1;
                    ha[h] = rnd_addr();
                end
            end
            do_cycle(hr, ha[0], ha[1], ($urandom % 4) == 0, g);
            if (g >= 0) hr[g] = 1'b0;
        end
        do_cycle(2'b00, 32'h0, 32'h0, 1'b0, g);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
